// File: rtl/div_radix2_iter_pkg.sv
// Shared constants and state encoding for the iterative radix-2 divider core.
package div_radix2_iter_pkg;

    // Default operand width (RV64); RV32 builds override XLEN on the core.
    localparam int DIV_XLEN  = 64;
    localparam int DIV_CNT_W = $clog2(DIV_XLEN) + 1;

    // Handshake and boolean levels used by the front-end/core interface.
    localparam logic DIV_START  = 1'b1;
    localparam logic DATA_VALID = 1'b1;
    localparam logic BOOL_TRUE  = 1'b1;
    localparam logic ZERO       = 1'b0;

    // Core sequencing states.
    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_radix2_iter_r2_step.sv
// One combinational restoring-division step: shift one dividend bit into the
// partial remainder, trial-subtract the divisor, and emit one quotient bit.
// Kept separate so a radix-4 variant can chain two of these per cycle.
module div_radix2_iter_r2_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] r_in,
    input  logic            q_msb,
    input  logic [XLEN-1:0] d_in,
    output logic [XLEN-1:0] r_out,
    output logic            q_bit
);

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;

    // The trial value is one bit wider than R so the bit shifted out of R's MSB
    // still takes part in the compare; when T >= D the difference is below D,
    // so the low XLEN bits of the subtraction hold it exactly.
    always_comb begin
        trial = {r_in, q_msb};
        diff  = trial[XLEN-1:0] - d_in;
        if (trial >= {1'b0, d_in}) begin
            r_out = diff;
            q_bit = 1'b1;
        end else begin
            r_out = trial[XLEN-1:0];
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/div_radix2_iter.sv
// Iterative unsigned radix-2 restoring divider core. Responds to the level
// start/hold handshake from the divide front end and returns a registered
// quotient and remainder, producing one quotient bit per cycle.
module div_radix2_iter
    import div_radix2_iter_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            hold,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            valid,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] rem
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] divr_q, divr_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] part_q, part_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] rem_q, rem_d;

    logic [XLEN-1:0] step_r;
    logic            step_bit;

    div_radix2_iter_r2_step #(
        .XLEN (XLEN)
    ) u_step (
        .r_in  (part_q),
        .q_msb (quo_q[XLEN-1]),
        .d_in  (divr_q),
        .r_out (step_r),
        .q_bit (step_bit)
    );

    // Next-state logic: operand capture in IDLE, one step per unstalled BUSY
    // cycle, abort on a dropped start, and result hand-off out of DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        divr_d  = divr_q;
        quo_d   = quo_q;
        part_d  = part_q;
        valid_d = valid_q;
        q_d     = q_q;
        rem_d   = rem_q;

        case (state_q)
            DIV_ST_IDLE: begin
                valid_d = ZERO;
                if (start == DIV_START && hold != BOOL_TRUE) begin
                    divr_d  = divisor;
                    quo_d   = dividend;
                    part_d  = '0;
                    cnt_d   = CNT_W'(XLEN);
                    state_d = DIV_ST_BUSY;
                end
            end
            DIV_ST_BUSY: begin
                if (start != DIV_START) begin
                    state_d = DIV_ST_IDLE;
                    valid_d = ZERO;
                end else if (hold != BOOL_TRUE) begin
                    part_d = step_r;
                    quo_d  = {quo_q[XLEN-2:0], step_bit};
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        q_d     = {quo_q[XLEN-2:0], step_bit};
                        rem_d   = step_r;
                        valid_d = DATA_VALID;
                        state_d = DIV_ST_DONE;
                    end
                end
            end
            DIV_ST_DONE: begin
                if (hold != BOOL_TRUE) begin
                    state_d = DIV_ST_IDLE;
                    valid_d = ZERO;
                end
            end
            default: begin
                state_d = DIV_ST_IDLE;
                valid_d = ZERO;
            end
        endcase
    end

    // All core state, cleared asynchronously so a reset aborts any operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            divr_q  <= '0;
            quo_q   <= '0;
            part_q  <= '0;
            valid_q <= ZERO;
            q_q     <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divr_q  <= divr_d;
            quo_q   <= quo_d;
            part_q  <= part_d;
            valid_q <= valid_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
        end
    end

    assign valid = valid_q;
    assign q     = q_q;
    assign rem   = rem_q;

endmodule

// File: tb/tb_div_radix2_iter.sv
// Self-checking bench for div_radix2_iter: directed scenarios plus randomized
// operations checked against a plain-arithmetic divide model.
module tb_div_radix2_iter;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] ALL1 = '1;
    localparam int LIMIT = 300;

    logic            clk;
    logic            rstn;
    logic            hold;
    logic            start;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            valid;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] rem;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN-1:0] last_q;
    logic [XLEN-1:0] last_rem;

    div_radix2_iter #(
        .XLEN (XLEN)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .hold     (hold),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .valid    (valid),
        .q        (q),
        .rem      (rem)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference divide from the arithmetic definition, including divide-by-zero.
    function automatic void ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                    output logic [XLEN-1:0] qq, output logic [XLEN-1:0] rr);
        if (b == 0) begin
            qq = ALL1;
            rr = a;
        end else begin
            qq = a / b;
            rr = a % b;
        end
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Issue one operation and wait for valid. cyc is the cycle number (start
    // edge opens cycle 1) in which valid is first seen; operand inputs are
    // scrambled while the core is busy to show they are not resampled.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int hold_at, input int hold_len,
                          output int cyc, output logic [XLEN-1:0] qo, output logic [XLEN-1:0] ro);
        int lat;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        hold     = 1'b0;
        tick();
        lat = 0;
        while (valid !== 1'b1 && lat < LIMIT) begin
            dividend = rand64();
            divisor  = rand64();
            hold     = (hold_len > 0 && lat >= hold_at && lat < hold_at + hold_len);
            tick();
            lat++;
        end
        hold = 1'b0;
        cyc  = lat + 1;
        qo   = q;
        ro   = rem;
    endtask

    // Consume a result: drop start, take the DONE edge, return to IDLE.
    task automatic end_op();
        start = 1'b0;
        hold  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; hold = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        repeat (2) tick();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid got=%0b want=0", valid); end
        n_cmp++; if (q !== '0) begin n_bad++; $display("[TB] FAIL reset_q got=%0h want=0", q); end
        n_cmp++; if (rem !== '0) begin n_bad++; $display("[TB] FAIL reset_rem got=%0h want=0", rem); end
        #2 rstn = 1'b1;
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_valid got=%0b want=0", valid); end
    endtask

    task automatic test_basic();
        int cyc; logic [XLEN-1:0] qo, ro;
        run_op(64'd100, 64'd7, -1, 0, cyc, qo, ro);
        n_cmp++; if (cyc !== XLEN + 1) begin n_bad++; $display("[TB] FAIL basic_latency got=%0d want=%0d", cyc, XLEN + 1); end
        n_cmp++; if (qo !== 64'd14) begin n_bad++; $display("[TB] FAIL basic_q got=%0d want=14", qo); end
        n_cmp++; if (ro !== 64'd2) begin n_bad++; $display("[TB] FAIL basic_rem got=%0d want=2", ro); end
        end_op();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_consume got=%0b want=0", valid); end
        last_q = 64'd14; last_rem = 64'd2;
        tick();
    endtask

    task automatic test_edge_values();
        logic [XLEN-1:0] av [4];
        logic [XLEN-1:0] bv [4];
        logic [XLEN-1:0] eq [4];
        logic [XLEN-1:0] er [4];
        int cyc; logic [XLEN-1:0] qo, ro;
        av[0] = ALL1;  bv[0] = 64'd1;  eq[0] = ALL1;  er[0] = 64'd0;
        av[1] = ALL1;  bv[1] = ALL1;   eq[1] = 64'd1; er[1] = 64'd0;
        av[2] = 64'd5; bv[2] = 64'd0;  eq[2] = ALL1;  er[2] = 64'd5;
        av[3] = 64'd3; bv[3] = 64'd10; eq[3] = 64'd0; er[3] = 64'd3;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], -1, 0, cyc, qo, ro);
            n_cmp++; if (qo !== eq[i]) begin n_bad++; $display("[TB] FAIL edge%0d_q got=%0h want=%0h", i, qo, eq[i]); end
            n_cmp++; if (ro !== er[i]) begin n_bad++; $display("[TB] FAIL edge%0d_rem got=%0h want=%0h", i, ro, er[i]); end
            n_cmp++; if (cyc !== XLEN + 1) begin n_bad++; $display("[TB] FAIL edge%0d_latency got=%0d want=%0d", i, cyc, XLEN + 1); end
            end_op();
            last_q = eq[i]; last_rem = er[i];
            tick();
        end
    endtask

    task automatic test_hold();
        int cyc; logic [XLEN-1:0] qo, ro;
        run_op(64'd1000, 64'd33, 20, 10, cyc, qo, ro);
        n_cmp++; if (cyc !== 75) begin n_bad++; $display("[TB] FAIL hold_latency got=%0d want=75", cyc); end
        n_cmp++; if (qo !== 64'd30) begin n_bad++; $display("[TB] FAIL hold_q got=%0d want=30", qo); end
        n_cmp++; if (ro !== 64'd10) begin n_bad++; $display("[TB] FAIL hold_rem got=%0d want=10", ro); end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hold = 1'b1;
            tick();
            n_cmp++; if (valid !== 1'b1 || q !== 64'd30 || rem !== 64'd10) begin
                n_bad++; $display("[TB] FAIL done_hold%0d got valid=%0b q=%0d rem=%0d want 1/30/10", i, valid, q, rem);
            end
        end
        hold = 1'b0;
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("[TB] FAIL done_release got=%0b want=0", valid); end
        last_q = 64'd30; last_rem = 64'd10;
        tick();
    endtask

    task automatic test_abort();
        int seen; int cyc; logic [XLEN-1:0] qo, ro;
        dividend = 64'd123456; divisor = 64'd789; start = 1'b1; hold = 1'b0;
        tick();
        repeat (19) tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("[TB] FAIL abort_valid got=%0d valid cycles want=0", seen); end
        n_cmp++; if (q !== last_q || rem !== last_rem) begin
            n_bad++; $display("[TB] FAIL abort_result got q=%0d rem=%0d want q=%0d rem=%0d", q, rem, last_q, last_rem);
        end
        run_op(64'd9, 64'd3, -1, 0, cyc, qo, ro);
        n_cmp++; if (cyc !== XLEN + 1) begin n_bad++; $display("[TB] FAIL abort_next_latency got=%0d want=%0d", cyc, XLEN + 1); end
        n_cmp++; if (qo !== 64'd3 || ro !== 64'd0) begin n_bad++; $display("[TB] FAIL abort_next got q=%0d rem=%0d want 3/0", qo, ro); end
        end_op();
        last_q = 64'd3; last_rem = 64'd0;
        tick();
    endtask

    task automatic test_async_reset();
        int cyc; logic [XLEN-1:0] qo, ro;
        dividend = 64'd100; divisor = 64'd7; start = 1'b1; hold = 1'b0;
        tick();
        repeat (30) tick();
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (valid !== 1'b0 || q !== '0 || rem !== '0) begin
            n_bad++; $display("[TB] FAIL async_reset got valid=%0b q=%0h rem=%0h want all 0", valid, q, rem);
        end
        start = 1'b0;
        #1 rstn = 1'b1;
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("[TB] FAIL post_reset_valid got=%0b want=0", valid); end
        run_op(64'd100, 64'd7, -1, 0, cyc, qo, ro);
        n_cmp++; if (cyc !== XLEN + 1) begin n_bad++; $display("[TB] FAIL post_reset_latency got=%0d want=%0d", cyc, XLEN + 1); end
        n_cmp++; if (qo !== 64'd14 || ro !== 64'd2) begin n_bad++; $display("[TB] FAIL post_reset_op got q=%0d rem=%0d want 14/2", qo, ro); end
        end_op();
        tick();
    endtask

    task automatic test_random();
        logic [XLEN-1:0] a, b, eq, er, qo, ro;
        int cyc, h_at, h_len;
        for (int n = 0; n < 24; n++) begin
            a = rand64() >> $urandom_range(0, 40);
            b = rand64() >> $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) b = '0;
            h_at  = $urandom_range(0, 60);
            h_len = $urandom_range(0, 4);
            ref_div(a, b, eq, er);
            run_op(a, b, h_at, h_len, cyc, qo, ro);
            n_cmp++; if (qo !== eq || ro !== er) begin
                n_bad++; $display("[TB] FAIL rand%0d %0h/%0h got q=%0h rem=%0h want q=%0h rem=%0h", n, a, b, qo, ro, eq, er);
            end
            n_cmp++; if (cyc !== XLEN + 1 + h_len) begin
                n_bad++; $display("[TB] FAIL rand%0d_latency got=%0d want=%0d", n, cyc, XLEN + 1 + h_len);
            end
            end_op();
            tick();
        end
    endtask

    initial begin
        last_q = '0; last_rem = '0;
        test_reset();
        test_basic();
        test_edge_values();
        test_hold();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_radix2_iter.md
Name: div_radix2_iter

Overview:
- Iterative unsigned radix-2 restoring divider core.
- Acts as the responder side of the start/valid/hold divider handshake driven by the RV divide unit.
- The front end handles sign conversion, divide-by-zero and overflow, then drives unsigned operands and a level start. This core returns quotient and remainder with a registered valid.
- One quotient bit is produced per cycle. The core is pin-compatible with the existing divider-core handshake.

Parameters:
- XLEN, 64: operand/result width (32 for RV32 builds).
- CNT_W, $clog2(XLEN)+1: iteration counter width.

Ports:
- clk  input  1  core clock
- rstn  input  1  reset, asynchronous, active-low
- hold  input  1  pipeline stall; freezes iteration and holds result
- start  input  1  level request from front end; operands valid while high
- dividend  input  XLEN  unsigned dividend
- divisor  input  XLEN  unsigned divisor
- valid  output  1  result valid (registered)
- q  output  XLEN  quotient (registered)
- rem  output  XLEN  remainder (registered)

Behaviour:
- Reset (rstn=0, async): state=IDLE; valid=0; q=0; rem=0; counter=0; internal operand/partial-remainder registers=0. Reset mid-operation aborts immediately; no result is produced.
- States:
  - IDLE: valid=0. At an edge with start=1 and hold=0:
    - latch divisor into D;
    - load quotient/shift register Q=dividend;
    - set partial remainder R=0 and counter=XLEN;
    - go to BUSY.
  - IDLE with start=1, hold=1: remain in IDLE.
  - BUSY, one step per edge when hold=0 and start=1:
    - T = {R[XLEN-2:0], Q[XLEN-1]} computed XLEN+1 wide as {R, Q[XLEN-1]};
    - if T >= D: R = T - D and shift 1 into Q LSB; else R = T and shift 0 into Q LSB;
    - counter decrements.
    - When counter==1 and the step executes, copy the final Q into q and R into rem, set valid=1, go to DONE.
  - BUSY with hold=1: all registers frozen; counter unchanged.
  - BUSY with start=0 (front-end flush/kill): return to IDLE next edge; valid stays 0; q/rem unchanged. Start has priority over hold for abort.
  - DONE: valid=1, and q/rem stable.
    - hold=1: stay in DONE.
    - hold=0: the result is consumed at this edge; go to IDLE and set valid=0 the next cycle. A start seen in DONE is ignored; the front end drops start while valid=1.
- Latency: start sampled in IDLE at edge E0. The XLEN steps occupy edges E1..EXLEN. valid is high in the cycle after EXLEN, i.e. XLEN+1 cycles after the start edge, plus one per hold cycle in BUSY.
- Arithmetic:
  - The compare/subtract is XLEN+1 bits wide to avoid losing the shifted-out R MSB. The remainder is always < D.
  - divisor=0 (not issued by the front end, but defined): every step subtracts 0, so q=all ones and rem=dividend.
  - dividend < divisor: q=0, rem=dividend.
- Operands are sampled only at the IDLE->BUSY edge. Input changes during BUSY are ignored except for start.
- No back-to-back issue: at least one IDLE cycle separates operations.

Decomposition:
- Shared params.v holds: XLEN, DIV_START, DATA_VALID, BOOL_TRUE, ZERO, and a new DIV_CNT_W.
- State encodings (DIV_ST_IDLE/BUSY/DONE, 2 bits) are added to params.v.
- One sub-module, div_r2_step: a combinational single restoring step. Inputs R, Q MSB, D; outputs next R and quotient bit. It is isolated so a future radix-4 variant can instantiate two per cycle.

Test Plan (XLEN=64):
- dividend=100, divisor=7, start held until valid -> valid=1 exactly 65 cycles after the start edge, with q=14 and rem=2.
- dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=1 -> q=0xFFFF_FFFF_FFFF_FFFF, rem=0. Then divisor=0xFFFF_FFFF_FFFF_FFFF -> q=1, rem=0.
- dividend=5, divisor=0 -> q=0xFFFF_FFFF_FFFF_FFFF, rem=5. Also dividend=3, divisor=10 -> q=0, rem=3.
- 1000/33 with hold=1 for 10 cycles mid-BUSY, then hold=1 for 3 cycles in DONE:
  - valid rises at cycle 75 and stays high through the 3 DONE hold cycles, with q=30 and rem=10;
  - valid drops one cycle after hold=0.
- start dropped at cycle 20 of BUSY, then 9/3 issued -> no valid for the aborted op; second op gives q=3, rem=0 after 65 cycles.
- rstn pulsed low asynchronously mid-BUSY (between edges) -> valid/q/rem go to 0 immediately. After release the core is in IDLE and a new 100/7 returns q=14, rem=2.
